// File: rtl/bc_pkg.sv
// ============================================================================
// Module   : bc_pkg
// Brief    : Shared Basic Computer constants: default widths and timing states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bc_pkg;

    localparam int SC_WIDTH_DEF   = 4;
    localparam int ICNT_WIDTH_DEF = 16;

    // Timing states decoded by the control unit.
    localparam logic [SC_WIDTH_DEF-1:0] T0 = 4'd0;
    localparam logic [SC_WIDTH_DEF-1:0] T1 = 4'd1;
    localparam logic [SC_WIDTH_DEF-1:0] T2 = 4'd2;
    localparam logic [SC_WIDTH_DEF-1:0] T3 = 4'd3;
    localparam logic [SC_WIDTH_DEF-1:0] T4 = 4'd4;
    localparam logic [SC_WIDTH_DEF-1:0] T5 = 4'd5;
    localparam logic [SC_WIDTH_DEF-1:0] T6 = 4'd6;

    localparam logic [SC_WIDTH_DEF-1:0] SC_ALL_ONES = '1;

endpackage

`default_nettype wire

// File: rtl/sequence_counter_if.sv
// ============================================================================
// Module   : sequence_counter_if
// Brief    : Control-unit <-> sequence counter signal bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sequence_counter_if
    import bc_pkg::*;
#(
    parameter int SC_WIDTH   = SC_WIDTH_DEF,
    parameter int ICNT_WIDTH = ICNT_WIDTH_DEF
);
    logic                  start;
    logic                  hlt;
    logic                  sc_clr;
    logic                  stall;
    logic [SC_WIDTH-1:0]   sc;
    logic                  running;
    logic                  wrap;
    logic [ICNT_WIDTH-1:0] icnt;

    modport master (
        output start, hlt, sc_clr, stall,
        input  sc, running, wrap, icnt
    );

    modport slave (
        input  start, hlt, sc_clr, stall,
        output sc, running, wrap, icnt
    );
endinterface

`default_nettype wire

// File: rtl/up_counter.sv
// ============================================================================
// Module   : up_counter
// Brief    : Free-running up counter with sync clear, enable and wrap pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module up_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_wrap
);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    // Clear beats enable; wrap marks only a genuine rollover by increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_en) begin
                r_count <= r_count + C_ONE;
                r_wrap  <= (r_count == C_ALL_ONES);
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule

`default_nettype wire

// File: rtl/sequence_counter.sv
// ============================================================================
// Module   : sequence_counter
// Brief    : Basic Computer SC register, start/stop flip-flop S and
//            retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sequence_counter
    import bc_pkg::*;
#(
    parameter int SC_WIDTH   = SC_WIDTH_DEF,
    parameter int ICNT_WIDTH = ICNT_WIDTH_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sequence_counter_if.slave bus
);
    logic                  r_running;
    logic                  w_start_ok;
    logic                  w_sc_clr;
    logic                  w_sc_en;
    logic                  w_icnt_en;
    logic [SC_WIDTH-1:0]   w_sc;
    logic                  w_sc_wrap;
    logic [ICNT_WIDTH-1:0] w_icnt;
    logic                  w_icnt_wrap_unused;

    assign w_start_ok = bus.start & ~r_running;

    // Halt, an accepted start and an in-run clear all force SC back to T0.
    assign w_sc_clr  = bus.hlt | w_start_ok | (r_running & bus.sc_clr);
    assign w_sc_en   = r_running & ~bus.stall;
    assign w_icnt_en = r_running & bus.sc_clr & ~bus.hlt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_running <= 1'b0;
        end else if (bus.hlt) begin
            r_running <= 1'b0;
        end else if (bus.start) begin
            r_running <= 1'b1;
        end
    end

    up_counter #(
        .WIDTH (SC_WIDTH)
    ) u_sc_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_sc_clr),
        .i_en    (w_sc_en),
        .o_count (w_sc),
        .o_wrap  (w_sc_wrap)
    );

    up_counter #(
        .WIDTH (ICNT_WIDTH)
    ) u_icnt_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    (w_icnt_en),
        .o_count (w_icnt),
        .o_wrap  (w_icnt_wrap_unused)
    );

    assign bus.sc      = w_sc;
    assign bus.running = r_running;
    assign bus.wrap    = w_sc_wrap;
    assign bus.icnt    = w_icnt;

endmodule

`default_nettype wire

// File: tb/tb_sequence_counter.sv
// ============================================================================
// Module   : tb_sequence_counter
// Brief    : Directed-vector bench with expectation queue and monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sequence_counter;

    logic clk;
    logic rst;

    sequence_counter_if #(.SC_WIDTH(4), .ICNT_WIDTH(16)) bus ();

    sequence_counter #(.SC_WIDTH(4), .ICNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          id;
        logic [3:0]  sc;
        logic        run;
        logic        wrap;
        logic [15:0] icnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic s, input logic h,
                        input logic c, input logic st,
                        input logic [3:0] e_sc, input logic e_run,
                        input logic e_wrap, input logic [15:0] e_icnt);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.start  = s;
        bus.hlt    = h;
        bus.sc_clr = c;
        bus.stall  = st;
        step_id++;
        e.id = step_id; e.sc = e_sc; e.run = e_run; e.wrap = e_wrap; e.icnt = e_icnt;
        sb.push_back(e);
    endtask

    // Monitor: every edge produces a state the bench has an expectation for.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.sc !== e.sc) begin
                    n_fail++;
                    $display("FAIL sc step %0d: got %0d expected %0d", e.id, bus.sc, e.sc);
                end
                n_checks++;
                if (bus.running !== e.run) begin
                    n_fail++;
                    $display("FAIL running step %0d: got %0b expected %0b", e.id, bus.running, e.run);
                end
                n_checks++;
                if (bus.wrap !== e.wrap) begin
                    n_fail++;
                    $display("FAIL wrap step %0d: got %0b expected %0b", e.id, bus.wrap, e.wrap);
                end
                n_checks++;
                if (bus.icnt !== e.icnt) begin
                    n_fail++;
                    $display("FAIL icnt step %0d: got %0d expected %0d", e.id, bus.icnt, e.icnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.hlt = 1'b0; bus.sc_clr = 1'b0; bus.stall = 1'b0;

        // Reset then idle; sc_clr/stall while stopped must do nothing.
        step(1, 0, 0, 0, 0, 4'd0, 0, 0, 16'd0);
        step(1, 0, 0, 0, 0, 4'd0, 0, 0, 16'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 4'd0, 0, 0, 16'd0);
        step(0, 0, 0, 1, 0, 4'd0, 0, 0, 16'd0);
        step(0, 0, 0, 0, 1, 4'd0, 0, 0, 16'd0);

        // Start and free run: 0..15,0,1 with wrap only on the rollover.
        step(0, 1, 0, 0, 0, 4'd0, 1, 0, 16'd0);
        for (int k = 1; k <= 17; k++)
            step(0, 0, 0, 0, 0, 4'(k % 16), 1, (k == 16), 16'd0);

        // Instruction loop: clear at T3 four times (sc currently 1).
        step(0, 0, 0, 0, 0, 4'd2, 1, 0, 16'd0);
        step(0, 0, 0, 0, 0, 4'd3, 1, 0, 16'd0);
        step(0, 0, 0, 1, 0, 4'd0, 1, 0, 16'd1);
        for (int n = 2; n <= 4; n++) begin
            step(0, 0, 0, 0, 0, 4'd1, 1, 0, 16'(n - 1));
            step(0, 0, 0, 0, 0, 4'd2, 1, 0, 16'(n - 1));
            step(0, 0, 0, 0, 0, 4'd3, 1, 0, 16'(n - 1));
            step(0, 0, 0, 1, 0, 4'd0, 1, 0, 16'(n));
        end

        // Stall precedence.
        step(0, 0, 0, 0, 0, 4'd1, 1, 0, 16'd4);
        step(0, 0, 0, 0, 0, 4'd2, 1, 0, 16'd4);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 4'd2, 1, 0, 16'd4);
        step(0, 0, 0, 1, 1, 4'd0, 1, 0, 16'd5);

        // Halt wins over sc_clr and start at T5.
        for (int k = 1; k <= 5; k++) step(0, 0, 0, 0, 0, 4'(k), 1, 0, 16'd5);
        step(0, 1, 1, 1, 0, 4'd0, 0, 0, 16'd5);
        step(0, 0, 0, 1, 0, 4'd0, 0, 0, 16'd5);
        step(0, 0, 0, 1, 1, 4'd0, 0, 0, 16'd5);
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 16'd5);
        step(0, 1, 0, 0, 0, 4'd0, 1, 0, 16'd5);
        step(0, 0, 0, 0, 0, 4'd1, 1, 0, 16'd5);
        // Start while running is ignored; sc_clr still applies alongside it.
        step(0, 1, 0, 0, 0, 4'd2, 1, 0, 16'd5);
        step(0, 1, 0, 1, 0, 4'd0, 1, 0, 16'd6);

        // Mid-run reset at T9 with icnt=7 and stall held.
        step(0, 0, 0, 0, 0, 4'd1, 1, 0, 16'd6);
        step(0, 0, 0, 1, 0, 4'd0, 1, 0, 16'd7);
        for (int k = 1; k <= 9; k++) step(0, 0, 0, 0, 0, 4'(k), 1, 0, 16'd7);
        step(1, 0, 0, 0, 1, 4'd0, 0, 0, 16'd0);
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 16'd0);
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 16'd0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
